// File: rtl/rv_decode_pipe_pkg.sv
// Shared RV32 decode definitions: opcodes, function-7 patterns, class enum and control/decode structs.
// The optional M-extension decode is enabled with the DECODE_M_EXT_EN macro.
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_R       = 4'd1,
        CLS_I_ALU   = 4'd2,
        CLS_LOAD    = 4'd3,
        CLS_STORE   = 4'd4,
        CLS_BRANCH  = 4'd5,
        CLS_LUI     = 4'd6,
        CLS_AUIPC   = 4'd7,
        CLS_JAL     = 4'd8,
        CLS_JALR    = 4'd9,
        CLS_MULDIV  = 4'd10
    } class_e;

    // Field order gives the packed layout {alu, branch, jump, mem_rd, mem_wr, reg_wr, illegal}
    typedef struct packed {
        logic alu;
        logic branch;
        logic jump;
        logic mem_rd;
        logic mem_wr;
        logic reg_wr;
        logic illegal;
    } ctrl_t;

    typedef struct packed {
        class_e      cls;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        ctrl_t       ctrl;
    } dec_t;

endpackage

// File: rtl/rv_decode_pipe_imm_gen.sv
// Combinational immediate generator: builds the 32-bit format immediate selected by the decoded
// class and sign-extends it to XLEN. Classes without an immediate (R, MULDIV, ILLEGAL) yield zero.
module rv_imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:7]      i_instr,
    input  class_e           i_cls,
    output logic [XLEN-1:0]  o_imm
);

    logic signed [31:0] w_imm32;

    always_comb begin
        w_imm32 = '0;
        case (i_cls)
            CLS_I_ALU, CLS_LOAD, CLS_JALR:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            CLS_STORE:
                w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            CLS_BRANCH:
                w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25],
                           i_instr[11:8], 1'b0};
            CLS_LUI, CLS_AUIPC:
                w_imm32 = {i_instr[31:12], 12'b0};
            CLS_JAL:
                w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20],
                           i_instr[30:21], 1'b0};
            default:
                w_imm32 = '0;
        endcase
    end

    // Signed size cast performs the sign extension for XLEN=64
    assign o_imm = XLEN'(w_imm32);

endmodule

// File: rtl/rv_decode_pipe.sv
// RV32 instruction decoder with a registered two-entry (main + skid) output buffer and a
// saturating illegal-instruction counter. Define DECODE_M_EXT_EN to decode MUL/DIV as class MULDIV.
module rv_decode_pipe
    import rv_decode_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [3:0]        out_class,
    output logic [4:0]        out_rd,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [2:0]        out_f3,
    output logic [6:0]        out_f7,
    output logic [XLEN-1:0]   out_imm,
    output logic [6:0]        out_ctrl,
    output logic [CNT_W-1:0]  illegal_cnt
);

    dec_t              w_dec;
    logic [XLEN-1:0]   w_imm;
    logic              w_accept;
    logic              w_pop;

    dec_t              r_mainDec;
    dec_t              r_skidDec;
    logic [XLEN-1:0]   r_mainPc;
    logic [XLEN-1:0]   r_skidPc;
    logic [XLEN-1:0]   r_mainImm;
    logic [XLEN-1:0]   r_skidImm;
    logic              r_mainValid;
    logic              r_skidValid;
    logic              r_inReady;
    logic [CNT_W-1:0]  r_illegalCnt;

    always_comb begin
        w_dec = '0;
        case (in_instr[6:0])
            OPC_OP: begin
                if (in_instr[31:25] == F7_BASE || in_instr[31:25] == F7_ALT) begin
                    w_dec.cls         = CLS_R;
                    w_dec.rd          = in_instr[11:7];
                    w_dec.rs1         = in_instr[19:15];
                    w_dec.rs2         = in_instr[24:20];
                    w_dec.f3          = in_instr[14:12];
                    w_dec.f7          = in_instr[31:25];
                    w_dec.ctrl.alu    = 1'b1;
                    w_dec.ctrl.reg_wr = 1'b1;
                end else if (in_instr[31:25] == F7_MULDIV) begin
`ifdef DECODE_M_EXT_EN
                    w_dec.cls         = CLS_MULDIV;
                    w_dec.rd          = in_instr[11:7];
                    w_dec.rs1         = in_instr[19:15];
                    w_dec.rs2         = in_instr[24:20];
                    w_dec.f3          = in_instr[14:12];
                    w_dec.f7          = in_instr[31:25];
                    w_dec.ctrl.reg_wr = 1'b1;
`else
                    w_dec.cls         = CLS_ILLEGAL;
`endif
                end
            end
            OPC_OP_IMM: begin
                w_dec.cls         = CLS_I_ALU;
                w_dec.rd          = in_instr[11:7];
                w_dec.rs1         = in_instr[19:15];
                w_dec.f3          = in_instr[14:12];
                w_dec.ctrl.alu    = 1'b1;
                w_dec.ctrl.reg_wr = 1'b1;
            end
            OPC_LOAD: begin
                w_dec.cls         = CLS_LOAD;
                w_dec.rd          = in_instr[11:7];
                w_dec.rs1         = in_instr[19:15];
                w_dec.f3          = in_instr[14:12];
                w_dec.ctrl.mem_rd = 1'b1;
                w_dec.ctrl.reg_wr = 1'b1;
            end
            OPC_STORE: begin
                w_dec.cls         = CLS_STORE;
                w_dec.rs1         = in_instr[19:15];
                w_dec.rs2         = in_instr[24:20];
                w_dec.f3          = in_instr[14:12];
                w_dec.ctrl.mem_wr = 1'b1;
            end
            OPC_BRANCH: begin
                w_dec.cls         = CLS_BRANCH;
                w_dec.rs1         = in_instr[19:15];
                w_dec.rs2         = in_instr[24:20];
                w_dec.f3          = in_instr[14:12];
                w_dec.ctrl.branch = 1'b1;
            end
            OPC_LUI, OPC_AUIPC: begin
                w_dec.cls         = (in_instr[6:0] == OPC_LUI) ? CLS_LUI : CLS_AUIPC;
                w_dec.rd          = in_instr[11:7];
                w_dec.ctrl.alu    = 1'b1;
                w_dec.ctrl.reg_wr = 1'b1;
            end
            OPC_JAL: begin
                w_dec.cls         = CLS_JAL;
                w_dec.rd          = in_instr[11:7];
                w_dec.ctrl.jump   = 1'b1;
                w_dec.ctrl.reg_wr = 1'b1;
            end
            OPC_JALR: begin
                w_dec.cls         = CLS_JALR;
                w_dec.rd          = in_instr[11:7];
                w_dec.rs1         = in_instr[19:15];
                w_dec.f3          = in_instr[14:12];
                w_dec.ctrl.jump   = 1'b1;
                w_dec.ctrl.reg_wr = 1'b1;
            end
            default: w_dec = '0;
        endcase
        w_dec.ctrl.illegal = (w_dec.cls == CLS_ILLEGAL);
    end

    rv_imm_gen #(.XLEN(XLEN)) u_immGen (
        .i_instr (in_instr[31:7]),
        .i_cls   (w_dec.cls),
        .o_imm   (w_imm)
    );

    assign w_accept = in_valid & r_inReady;
    assign w_pop    = r_mainValid & out_ready;

    // Skid buffer: the skid entry only fills while main is stalled, and in_ready mirrors its emptiness
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
            r_mainDec   <= '0;
            r_skidDec   <= '0;
            r_mainPc    <= '0;
            r_skidPc    <= '0;
            r_mainImm   <= '0;
            r_skidImm   <= '0;
        end else if (flush) begin
            r_mainValid <= 1'b0;
            r_skidValid <= 1'b0;
            r_inReady   <= 1'b1;
        end else if (w_pop) begin
            if (r_skidValid) begin
                r_mainDec   <= r_skidDec;
                r_mainPc    <= r_skidPc;
                r_mainImm   <= r_skidImm;
                r_skidValid <= 1'b0;
                r_inReady   <= 1'b1;
            end else if (w_accept) begin
                r_mainDec   <= w_dec;
                r_mainPc    <= in_pc;
                r_mainImm   <= w_imm;
            end else begin
                r_mainValid <= 1'b0;
            end
        end else if (w_accept) begin
            if (r_mainValid) begin
                r_skidDec   <= w_dec;
                r_skidPc    <= in_pc;
                r_skidImm   <= w_imm;
                r_skidValid <= 1'b1;
                r_inReady   <= 1'b0;
            end else begin
                r_mainDec   <= w_dec;
                r_mainPc    <= in_pc;
                r_mainImm   <= w_imm;
                r_mainValid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_illegalCnt <= '0;
        end else if (w_accept && !flush && w_dec.ctrl.illegal && (r_illegalCnt != '1)) begin
            r_illegalCnt <= r_illegalCnt + CNT_W'(1);
        end
    end

    assign in_ready    = r_inReady;
    assign out_valid   = r_mainValid;
    assign out_pc      = r_mainPc;
    assign out_class   = r_mainDec.cls;
    assign out_rd      = r_mainDec.rd;
    assign out_rs1     = r_mainDec.rs1;
    assign out_rs2     = r_mainDec.rs2;
    assign out_f3      = r_mainDec.f3;
    assign out_f7      = r_mainDec.f7;
    assign out_imm     = r_mainImm;
    assign out_ctrl    = r_mainDec.ctrl;
    assign illegal_cnt = r_illegalCnt;

endmodule
